mmio_console_agent: RTL and testbench
=====================================

MMIO_CONSOLE_AGENT -- requirements
Module: mmio_console_agent

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'hF000_0000, base of the 16-byte register window.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, console FIFO entries; power of two, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port address, input, 32, data-bus byte address from the CPU manager.
REQ-006 SHALL have port read, input, 1, read request.
REQ-007 SHALL have port write, input, 1, write request.
REQ-008 SHALL have port byteenable, input, 4, write byte lanes.
REQ-009 SHALL have port host_to_agent, input, 32, write data.
REQ-010 SHALL have port agent_to_host, output, 32, read data.
REQ-011 SHALL have port waitrequest, output, 1, stall; the manager holds the request while it is high.
REQ-012 SHALL have port readdatavalid, output, 1, read data qualifier.
REQ-013 SHALL have port tx_valid, output, 1, console byte available.
REQ-014 SHALL have port tx_data, output, 8, console byte.
REQ-015 SHALL have port tx_ready, input, 1, consumer accepts the byte.
REQ-016 SHALL have port exit_valid, output, 1, program requested exit.
REQ-017 SHALL have port exit_code, output, 32, latched exit value.

Function
REQ-018 SHALL decode a hit only when address[31:4] equals BASE_ADDR[31:4]; a non-hit is ignored with waitrequest 0 and readdatavalid 0.
REQ-019 SHALL treat offset 0x0 as EXIT: a write sets exit_valid and latches the full 32-bit host_to_agent into exit_code, regardless of byteenable.
REQ-020 SHALL treat offset 0x4 as TXDATA: a write with byteenable[0]=1 pushes host_to_agent[7:0] into the FIFO; a write with byteenable[0]=0 completes without pushing.
REQ-021 SHALL treat offset 0x8 as STATUS (read-only): bit0 = FIFO empty, bit1 = FIFO full, bit2 = exit_valid, bits[15:8] = FIFO level, all other bits 0.
REQ-022 SHALL treat offset 0xC as CYCLES (see Configuration); writes to 0x8 and 0xC SHALL be ignored.
REQ-023 SHALL assert waitrequest combinationally during a TXDATA write while the FIFO is full and tx_ready is 0; the write completes in the first cycle a slot is free.
REQ-024 SHALL, for a push while full with tx_ready=1 in the same cycle, pop and push together with no stall and no level change.
REQ-025 SHALL complete every read with waitrequest 0 and assert readdatavalid with agent_to_host exactly one cycle later; at all other times agent_to_host SHALL be 0.
REQ-026 SHALL present the FIFO head on tx_data with tx_valid = not empty; a pop occurs on tx_valid and tx_ready.
REQ-027 SHALL pop at most one and push at most one byte per cycle; an empty FIFO with simultaneous push and tx_ready pops nothing that cycle (no bypass).
REQ-028 SHALL wrap FIFO read and write pointers modulo FIFO_DEPTH and keep the level in clog2(FIFO_DEPTH)+1 bits.
REQ-029 SHALL keep exit_valid high until reset; a later EXIT write overwrites exit_code.
REQ-030 SHALL give read and write asserted together the write priority; the read SHALL be dropped, with no readdatavalid.

Reset
REQ-031 SHALL, while rst is high, force empty FIFO, tx_valid 0, tx_data 0, exit_valid 0, exit_code 0, agent_to_host 0, readdatavalid 0, waitrequest 0, and CYCLES 0.
REQ-032 SHALL discard FIFO contents and any pending read response when rst asserts mid-operation.
REQ-033 SHALL treat the first rising edge after rst deasserts as a normal operating cycle.

Configuration
REQ-034 SHALL, with macro CONSOLE_CYCLE_COUNTER_EN defined, implement a 32-bit free-running counter, incremented every clk and wrapping at 2^32, readable at 0xC.
REQ-035 SHALL, without CONSOLE_CYCLE_COUNTER_EN, contain no counter logic, with reads of 0xC returning 0.

Verification
REQ-036 SHALL cover: write 32'h0000_002A to 0xF000_0000 -> exit_valid 1 and exit_code 32'h2A next cycle; STATUS bit2 reads 1.
REQ-037 SHALL cover: tx_ready=0, 17 TXDATA writes with FIFO_DEPTH=16 -> the 17th stalls (waitrequest 1); raising tx_ready completes it; 17 bytes emerge in order.
REQ-038 SHALL cover: read 0xF000_0008 after 3 pushes -> readdatavalid one cycle later, data 32'h0000_0300.
REQ-039 SHALL cover: FIFO full, push with tx_ready=1 -> no stall, level stays 16, byte order preserved.
REQ-040 SHALL cover: rst pulsed with 5 bytes queued and exit_valid set -> tx_valid 0, exit_valid 0, STATUS reads 32'h1.
REQ-041 SHALL cover: with CONSOLE_CYCLE_COUNTER_EN, two CYCLES reads issued 10 cycles apart -> difference 10; without the macro -> both read 0.

Source files
------------

// File: rtl/mmio_console_agent.sv
// mmio_console_agent
// Memory-mapped console/exit agent for a CPU data bus. It decodes a 16-byte
// register window at BASE_ADDR:
//   0x0 EXIT    (W)  latch exit code, raise exit_valid
//   0x4 TXDATA  (W)  push host_to_agent[7:0] into the console FIFO
//   0x8 STATUS  (R)  {16'h0, level[7:0], 5'h0, exit_valid, full, empty}
//   0xC CYCLES  (R)  free-running cycle count, or 0 when not built in
// Optional feature: define CONSOLE_CYCLE_COUNTER_EN to build the cycle counter.
// Read data returns one cycle after the request with readdatavalid.
module mmio_console_agent #(
    parameter logic [31:0] BASE_ADDR  = 32'hF000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [3:0]  byteenable,
    input  logic [31:0] host_to_agent,
    output logic [31:0] agent_to_host,
    output logic        waitrequest,
    output logic        readdatavalid,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        exit_valid,
    output logic [31:0] exit_code
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [LW-1:0] r_level;
    logic          r_exit_valid;
    logic [31:0]   r_exit_code;
    logic          r_rvalid;
    logic [31:0]   r_rdata;

    logic          w_hit;
    logic          w_wr;
    logic          w_rd;
    logic          w_sel_exit;
    logic          w_sel_tx;
    logic          w_sel_status;
    logic          w_sel_cycles;
    logic          w_empty;
    logic          w_full;
    logic          w_tx_wr;
    logic          w_push;
    logic          w_pop;
    logic [7:0]    w_level8;
    logic [31:0]   w_cycles;
    logic [31:0]   w_rdata;
    logic          w_unused_bits;

    // Only the low byte lane matters for TXDATA; EXIT ignores lanes entirely.
    assign w_unused_bits = &{1'b0, byteenable[3:1]};

    assign w_hit        = (address[31:4] == BASE_ADDR[31:4]);
    assign w_wr         = w_hit & write;
    assign w_rd         = w_hit & read & ~write;
    assign w_sel_exit   = (address[3:0] == 4'h0);
    assign w_sel_tx     = (address[3:0] == 4'h4);
    assign w_sel_status = (address[3:0] == 4'h8);
    assign w_sel_cycles = (address[3:0] == 4'hC);

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LW'(FIFO_DEPTH));
    assign w_level8 = 8'(r_level);

    // A full FIFO only stalls the writer when the consumer is not draining
    // the head in the same cycle; with tx_ready high pop and push overlap.
    assign w_tx_wr     = w_wr & w_sel_tx & byteenable[0];
    assign w_pop       = ~w_empty & tx_ready;
    assign w_push      = w_tx_wr & (~w_full | tx_ready);
    assign waitrequest = w_tx_wr & w_full & ~tx_ready;

    assign tx_valid      = ~w_empty;
    assign tx_data       = w_empty ? 8'h00 : r_mem[r_rptr];
    assign exit_valid    = r_exit_valid;
    assign exit_code     = r_exit_code;
    assign readdatavalid = r_rvalid;
    assign agent_to_host = r_rdata;

`ifdef CONSOLE_CYCLE_COUNTER_EN
    logic [31:0] r_cycles;

    // Free-running cycle counter, wraps naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycles <= '0;
        end else begin
            r_cycles <= r_cycles + 32'd1;
        end
    end

    assign w_cycles = r_cycles;
`else
    assign w_cycles = 32'd0;
`endif

    // Read data mux; unmapped and write-only offsets read as zero.
    always_comb begin
        w_rdata = 32'd0;
        if (w_sel_status) begin
            w_rdata = {16'h0000, w_level8, 5'b00000, r_exit_valid, w_full, w_empty};
        end else if (w_sel_cycles) begin
            w_rdata = w_cycles;
        end
    end

    // FIFO storage; contents need no reset because the level gates visibility.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= host_to_agent[7:0];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Exit latch: sticky flag, code overwritten by every EXIT write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exit_valid <= 1'b0;
            r_exit_code  <= '0;
        end else if (w_wr & w_sel_exit) begin
            r_exit_valid <= 1'b1;
            r_exit_code  <= host_to_agent;
        end
    end

    // Registered read response; data is forced to zero when not valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            r_rdata  <= w_rd ? w_rdata : 32'd0;
        end
    end

endmodule

// File: tb/tb_mmio_console_agent.sv
// Bench for mmio_console_agent: directed scenarios followed by a randomized
// run, all checked every cycle against a queue-based model of the agent.
module tb_mmio_console_agent;

    localparam logic [31:0] BASE  = 32'hF000_0000;
    localparam int          DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [3:0]  byteenable = '0;
    logic [31:0] host_to_agent = '0;
    logic [31:0] agent_to_host;
    logic        waitrequest;
    logic        readdatavalid;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        exit_valid;
    logic [31:0] exit_code;

    always #5 clk = ~clk;

    mmio_console_agent #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .address(address), .read(read), .write(write),
        .byteenable(byteenable), .host_to_agent(host_to_agent),
        .agent_to_host(agent_to_host), .waitrequest(waitrequest),
        .readdatavalid(readdatavalid), .tx_valid(tx_valid), .tx_data(tx_data),
        .tx_ready(tx_ready), .exit_valid(exit_valid), .exit_code(exit_code)
    );

    // reference model state
    logic [7:0]  m_q[$];
    logic        m_exit_v;
    logic [31:0] m_exit_c;
    logic        m_rdv;
    logic [31:0] m_rdata;
    logic [31:0] m_cyc;

    logic        last_wait;
    logic        obs_wait;
    logic [31:0] last_rdata;
    logic [7:0]  obs_popped[$];

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] reg_value(input logic [31:0] a);
        logic [31:0] v;
        v = 32'd0;
        if (a[3:0] == 4'h8) begin
            v[0]    = (m_q.size() == 0);
            v[1]    = (m_q.size() == DEPTH);
            v[2]    = m_exit_v;
            v[15:8] = 8'(m_q.size());
        end else if (a[3:0] == 4'hC) begin
`ifdef CONSOLE_CYCLE_COUNTER_EN
            v = m_cyc;
`else
            v = 32'd0;
`endif
        end
        return v;
    endfunction

    // One clock: check outputs at the falling edge, advance the model, then
    // return 1 time unit after the rising edge so the caller can drive inputs.
    task automatic cycle();
        logic        hit, wr, rd, exp_wait, push, nrdv;
        logic [31:0] nrdata;
        @(negedge clk);
        if (rst) begin
            m_q.delete();
            m_exit_v = 1'b0;
            m_exit_c = '0;
            m_rdv    = 1'b0;
            m_rdata  = '0;
            m_cyc    = '0;
        end
        hit = (address[31:4] == BASE[31:4]);
        wr  = hit && write;
        rd  = hit && read && !write;
        exp_wait = wr && address[3:0] == 4'h4 && byteenable[0] && m_q.size() == DEPTH && !tx_ready;

        check("waitrequest", {31'd0, waitrequest}, {31'd0, exp_wait});
        check("tx_valid", {31'd0, tx_valid}, {31'd0, m_q.size() != 0});
        check("tx_data", {24'd0, tx_data}, (m_q.size() != 0) ? {24'd0, m_q[0]} : 32'd0);
        check("readdatavalid", {31'd0, readdatavalid}, {31'd0, m_rdv});
        check("agent_to_host", agent_to_host, m_rdata);
        check("exit_valid", {31'd0, exit_valid}, {31'd0, m_exit_v});
        check("exit_code", exit_code, m_exit_c);

        last_wait  = exp_wait;
        obs_wait   = waitrequest;
        last_rdata = agent_to_host;
        if (!rst && tx_valid && tx_ready) obs_popped.push_back(tx_data);

        if (!rst) begin
            nrdv   = rd;
            nrdata = rd ? reg_value(address) : 32'd0;
            push   = wr && address[3:0] == 4'h4 && byteenable[0] && !exp_wait;
            if (m_q.size() != 0 && tx_ready) void'(m_q.pop_front());
            if (push) m_q.push_back(host_to_agent[7:0]);
            if (wr && address[3:0] == 4'h0) begin
                m_exit_v = 1'b1;
                m_exit_c = host_to_agent;
            end
            m_rdv   = nrdv;
            m_rdata = nrdata;
            m_cyc   = m_cyc + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        read = 1'b0; write = 1'b0; address = '0; byteenable = '0; host_to_agent = '0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        obs_popped.delete();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        logic done;
        done = 1'b0;
        address = a; host_to_agent = d; byteenable = be; write = 1'b1; read = 1'b0;
        for (int i = 0; i < 64; i++) begin
            cycle();
            if (!last_wait) begin
                done = 1'b1;
                break;
            end
        end
        check("write_done", {31'd0, done}, 32'd1);
        set_idle();
    endtask

    task automatic do_read(input logic [31:0] a);
        address = a; read = 1'b1; write = 1'b0;
        cycle();
        set_idle();
        cycle();
    endtask

    initial begin
        logic [31:0] v1, v2;
        int stalls;
        int ready_pct;

        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v1, v2;
        int stalls;
        int ready_pct;

        // reset state
        do_reset();
        check("rst_status_empty", {31'd0, tx_valid}, 32'd0);

        // EXIT write ignores byte lanes; STATUS bit2 follows
        do_write(BASE, 32'h0000_002A, 4'h0);
        check("exit_code_2a", exit_code, 32'h0000_002A);
        check("exit_valid_set", {31'd0, exit_valid}, 32'd1);
        do_read(BASE + 32'h8);
        check("status_exit_bit", {31'd0, last_rdata[2]}, 32'd1);
        do_write(BASE, 32'hDEAD_BEEF, 4'h1);
        check("exit_overwrite", exit_code, 32'hDEAD_BEEF);
        do_write(32'hF000_0010, 32'h55, 4'hF);
        do_write(BASE + 32'h4, 32'h77, 4'hE);
        check("no_push_be0", {31'd0, tx_valid}, 32'd0);

        // 17 writes into a 16-deep FIFO with the consumer stalled
        do_reset();
        tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) do_write(BASE + 32'h4, 32'(i), 4'h1);
        address = BASE + 32'h4; host_to_agent = 32'd17; byteenable = 4'h1; write = 1'b1;
        stalls = 0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            if (obs_wait) stalls++;
        end
        check("stall_count_17th", 32'(stalls), 32'd3);
        tx_ready = 1'b1;
        cycle();
        check("17th_completes", {31'd0, obs_wait}, 32'd0);
        set_idle();
        for (int i = 0; i < 20; i++) cycle();
        check("popped_count_17", 32'(obs_popped.size()), 32'd17);
        for (int i = 0; i < obs_popped.size(); i++)
            check("byte_order_17", {24'd0, obs_popped[i]}, 32'(i + 1));
        tx_ready = 1'b0;

        // STATUS after three pushes
        do_reset();
        for (int i = 0; i < 3; i++) do_write(BASE + 32'h4, 32'hA0 + 32'(i), 4'h1);
        do_read(BASE + 32'h8);
        check("status_3_pushes", last_rdata, 32'h0000_0300);

        // push while full with consumer ready: no stall, level stays 16
        do_reset();
        for (int i = 0; i < 16; i++) do_write(BASE + 32'h4, 32'h40 + 32'(i), 4'h1);
        obs_popped.delete();
        address = BASE + 32'h4; host_to_agent = 32'h99; byteenable = 4'h1; write = 1'b1;
        tx_ready = 1'b1;
        cycle();
        check("full_push_nostall", {31'd0, obs_wait}, 32'd0);
        set_idle();
        tx_ready = 1'b0;
        do_read(BASE + 32'h8);
        check("status_full_16", last_rdata, 32'h0000_1002);
        tx_ready = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("popped_count_full", 32'(obs_popped.size()), 32'd17);
        for (int i = 0; i < obs_popped.size(); i++)
            check("byte_order_full", {24'd0, obs_popped[i]},
                  (i < 16) ? 32'h40 + 32'(i) : 32'h99);
        tx_ready = 1'b0;

        // reset mid-operation
        do_reset();
        for (int i = 0; i < 5; i++) do_write(BASE + 32'h4, 32'h10 + 32'(i), 4'h1);
        do_write(BASE, 32'h0000_0007, 4'hF);
        rst = 1'b1;
        cycle();
        check("rst_mid_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_mid_exit_valid", {31'd0, exit_valid}, 32'd0);
        rst = 1'b0;
        do_read(BASE + 32'h8);
        check("rst_mid_status", last_rdata, 32'h0000_0001);

        // CYCLES reads ten cycles apart
        do_reset();
        do_read(BASE + 32'hC);
        v1 = last_rdata;
        for (int i = 0; i < 8; i++) cycle();
        do_read(BASE + 32'hC);
        v2 = last_rdata;
`ifdef CONSOLE_CYCLE_COUNTER_EN
        check("cycles_delta", v2 - v1, 32'd10);
`else
        check("cycles_first_zero", v1, 32'd0);
        check("cycles_second_zero", v2, 32'd0);
`endif

        // randomized traffic, model-checked every cycle
        do_reset();
        ready_pct = 20;
        for (int it = 0; it < 600; it++) begin
            if (it % 100 == 0) ready_pct = (ready_pct == 20) ? 85 : 20;
            tx_ready = ($urandom_range(0, 99) < ready_pct);
            if (!last_wait) begin
                rst = ($urandom_range(0, 199) == 0);
                case ($urandom_range(0, 7))
                    0:       address = BASE;
                    1, 2, 3: address = BASE + 32'h4;
                    4:       address = BASE + 32'h8;
                    5:       address = BASE + 32'hC;
                    6:       address = BASE + 32'($urandom_range(0, 15));
                    default: address = $urandom();
                endcase
                write         = ($urandom_range(0, 1) == 1);
                read          = ($urandom_range(0, 4) < 2);
                byteenable    = 4'($urandom_range(0, 15));
                host_to_agent = $urandom();
            end
            cycle();
        end
        rst = 1'b0;
        set_idle();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
